// File: rtl/descriptor_memory_arbiter.sv
// descriptor_memory_arbiter
// Shares a single-port descriptor RAM between the host configuration master
// (port 0) and the DMA descriptor-fetch engine (port 1). One RAM access per
// cycle, read data returned one cycle after acceptance, and a bounded lock
// so one master can finish an ownership-bit read-modify-write atomically.
//
// Build option:
//   DESC_ARB_ROUND_ROBIN_EN - on an unlocked conflict, the port not granted
//                             most recently wins. Without it, port 1 (DMA)
//                             always wins conflicts.
module descriptor_memory_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0: host / CPU
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_lock,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // port 1: DMA descriptor fetch
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_lock,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // descriptor RAM
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata,
  // status
  output logic                  lock_timeout
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               rd_vld_q, rd_vld_d;
  logic               rd_port_q;

  logic               req0_s, req1_s;
  logic               gnt0_s, gnt1_s;
  logic               prefer1_s;
  logic               lock_timeout_s;
  logic               wr_sel_s;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

`ifdef DESC_ARB_ROUND_ROBIN_EN
  // Last granted port; 0 after reset so port 1 is favoured first.
  logic last_q, last_d;

  assign prefer1_s = ~last_q;

  // Remember which port took the most recent transfer.
  always_comb begin
    last_d = last_q;
    if (gnt1_s) begin
      last_d = 1'b1;
    end else if (gnt0_s) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign prefer1_s = 1'b1;
`endif

  // Grant selection and lock state machine next-state logic.
  always_comb begin
    gnt0_s         = 1'b0;
    gnt1_s         = 1'b0;
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_s = 1'b0;
    if (reset) begin
      state_d    = UNLOCKED;
      lock_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (req0_s && req1_s) begin
            if (prefer1_s) begin
              gnt1_s = 1'b1;
            end else begin
              gnt0_s = 1'b1;
            end
          end else begin
            gnt0_s = req0_s;
            gnt1_s = req1_s;
          end
          if (gnt0_s && m0_lock) begin
            state_d    = LOCKED0;
            lock_cnt_d = CNT_ONE;
          end else if (gnt1_s && m1_lock) begin
            state_d    = LOCKED1;
            lock_cnt_d = CNT_ONE;
          end else begin
            state_d    = UNLOCKED;
            lock_cnt_d = CNT_ZERO;
          end
        end
        LOCKED0: begin
          // Owner keeps the RAM; port 1 stalls even while port 0 is idle.
          gnt0_s = req0_s;
          if (!m0_lock) begin
            state_d    = UNLOCKED;
            lock_cnt_d = CNT_ZERO;
          end else if (lock_cnt_q >= CNT_MAX) begin
            lock_timeout_s = 1'b1;
            state_d        = UNLOCKED;
            lock_cnt_d     = CNT_ZERO;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end
        LOCKED1: begin
          gnt1_s = req1_s;
          if (!m1_lock) begin
            state_d    = UNLOCKED;
            lock_cnt_d = CNT_ZERO;
          end else if (lock_cnt_q >= CNT_MAX) begin
            lock_timeout_s = 1'b1;
            state_d        = UNLOCKED;
            lock_cnt_d     = CNT_ZERO;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d    = UNLOCKED;
          lock_cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  // Route the winning master onto the RAM port.
  always_comb begin
    if (gnt1_s) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      wr_sel_s       = m1_write;
    end else begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      wr_sel_s       = m0_write;
    end
  end

  assign ram_chipselect = gnt0_s | gnt1_s;
  assign ram_write      = ram_chipselect & wr_sel_s;
  assign ram_clken      = 1'b1;

  assign m0_waitrequest = ~gnt0_s;
  assign m1_waitrequest = ~gnt1_s;
  assign lock_timeout   = lock_timeout_s;

  // A read-and-write request is a write, so only pure reads return data.
  always_comb begin
    rd_vld_d = (gnt0_s & m0_read & ~m0_write) | (gnt1_s & m1_read & ~m1_write);
  end

  // State, lock counter and read-return pipe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= CNT_ZERO;
      rd_vld_q   <= 1'b0;
      rd_port_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_port_q  <= gnt1_s;
    end
  end

  // Reset drops any return that is due in the same cycle.
  assign m0_readdatavalid = rd_vld_q & ~rd_port_q & ~reset;
  assign m1_readdatavalid = rd_vld_q &  rd_port_q & ~reset;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: doc/descriptor_memory_arbiter.md
# descriptor_memory_arbiter

Two-port Avalon-MM arbiter that shares the single-port 512x32 descriptor RAM between the host/CPU configuration master (port 0) and the DMA descriptor-fetch engine (port 1). It issues at most one access per cycle to the RAM, returns read data with a fixed one-cycle latency, and supports a bounded lock so one master can complete a descriptor read-modify-write (ownership-bit update) atomically. It sits between the system interconnect/DMA and the descriptor RAM instance.

## Interface
Parameters:
- ADDR_W, 9, RAM word-address width (512 words)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_LOCK, 16, maximum consecutive cycles a lock may be held before forced release (>=2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  port 0 word address
- m0_byteenable  in  DATA_W/8  port 0 byte enables (writes only)
- m0_read / m0_write  in  1 each  port 0 request strobes
- m0_writedata  in  DATA_W  port 0 write data
- m0_lock  in  1  port 0 requests to keep grant after this transfer
- m0_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata  out  DATA_W  read data, valid with m0_readdatavalid
- m0_readdatavalid  out  1  one-cycle pulse per accepted read
- m1_*  same set as m0_* for port 1 (DMA)
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byte enables
- ram_chipselect  out  1  RAM access this cycle
- ram_write  out  1  RAM write strobe (RAM wren = chipselect & write)
- ram_writedata  out  DATA_W  to RAM write data
- ram_clken  out  1  RAM clock enable; tied high
- ram_readdata  in  DATA_W  RAM q, valid one cycle after address
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

## Operation
- Request from port n = mn_read | mn_write. Read and write together is treated as a write; no readdatavalid.
- Grant is combinational each cycle: the winner gets waitrequest low and its address/byteenable/writedata/write muxed to the RAM with ram_chipselect=1; the loser gets waitrequest high and must hold its request stable.
- No request: ram_chipselect=0, both waitrequest high? No—waitrequest is low only for an accepted request; idle waitrequest = 1.
- Conflict resolution per Configuration section.
- States: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED -> LOCKEDn when port n is granted with mn_lock=1; lock counter loads 1.
  - LOCKEDn: only port n may be granted; other port stalls even if port n is idle. Counter increments every cycle.
  - LOCKEDn -> UNLOCKED when port n completes a granted transfer with mn_lock=0, or when mn_lock is low while idle, or when counter reaches MAX_LOCK (lock_timeout pulses, that cycle's grant still honoured, next cycle UNLOCKED).
- Read return: registered pipe records {valid, port} of an accepted read; next cycle mn_readdatavalid=1 for that port and mn_readdata = ram_readdata. Readdata to the non-returning port is don't-care (driven with ram_readdata).
- Back-to-back accepted reads from either port: one per cycle, returned in issue order, no bubbles.

## Timing
- Read latency: address accepted in cycle T, readdatavalid at T+1.
- Write: accepted in cycle T, RAM updated at edge ending T; a read to same address at T+1 returns new data.
- Reset values: waitrequest = 1 on both ports during reset cycle, readdatavalid = 0, lock_timeout = 0, ram_chipselect = 0, state UNLOCKED, counter 0, round-robin pointer = port 0 last granted (port 1 favoured next).
- Reset mid-operation: pending readdatavalid is dropped, lock released; no request is accepted while reset is high.
- Lock counter saturates at MAX_LOCK; never wraps.

## Configuration
- Macro DESC_ARB_ROUND_ROBIN_EN.
- Defined: on conflict in UNLOCKED, the port not granted most recently wins; pointer updates on every granted transfer.
- Undefined: fixed priority, port 1 (DMA) always wins conflicts; pointer logic absent. Lock behaviour identical in both builds.

## Test plan
- Single read: preload word 0x1A5 = 0xDEADBEEF; m1 reads 0x1A5 -> waitrequest low same cycle, m1_readdatavalid at T+1 with 0xDEADBEEF, m0_readdatavalid stays 0.
- Byte write: m0 writes 0x010, writedata 0x11223344, byteenable 4'b0101 over 0xFFFFFFFF -> subsequent read returns 0xFF22FF44.
- Conflict: both read every cycle for 4 cycles -> with DESC_ARB_ROUND_ROBIN_EN grants alternate 1,0,1,0; without, m1 granted all 4 and m0 waitrequest held high.
- Lock RMW: m0 reads 0x020 with lock=1, m1 requests continuously -> m1 stalled; m0 writes 0x020 with lock=0 next cycle -> m1 granted the following cycle, lock_timeout never pulses.
- Lock timeout: MAX_LOCK=16, m1 holds lock=1 idle -> lock_timeout pulses once at counter=16, m0 granted the next cycle.
- Reset mid-read: m0 read accepted at T, reset high at T+1 -> m0_readdatavalid 0 at T+1, all waitrequest 1, state UNLOCKED after reset.
